// File: rtl/ahb_txn_arbiter.sv
// Round-robin arbiter that replays one granted command at a time
// on the AHB_module enable/Wr/address/data pins.
module ahb_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int XFER_CYCLES = 3
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [2*NREQ-1:0]    req_sel,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_d1,
    input  logic [32*NREQ-1:0]   req_d2,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rdata,
    output logic                 enable,
    output logic                 Wr,
    output logic [1:0]           slave_sel,
    output logic [31:0]          addr,
    output logic [31:0]          data_in_1,
    output logic [31:0]          data_in_2,
    input  logic [31:0]          d_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(XFER_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            cwr_q, cwr_d;
    logic [31:0]     cd1_q, cd1_d;
    logic [31:0]     cd2_q, cd2_d;
    logic            enable_q, enable_d;
    logic            wr_q, wr_d;
    logic [1:0]      sel_q, sel_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     din1_q, din1_d;
    logic [31:0]     din2_q, din2_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            any_req;
    logic [PW-1:0]   win;
    logic [PW-1:0]   ptr_nxt;

    // First asserted request at or after ptr, wrapping around.
    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    assign any_req = |req;
    assign ptr_nxt = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

    assign gnt = (Hresetn && state_q == S_IDLE && any_req)
               ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        cwr_d    = cwr_q;
        cd1_d    = cd1_q;
        cd2_d    = cd2_q;
        enable_d = enable_q;
        wr_d     = wr_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        din1_d   = din1_q;
        din2_d   = din2_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d  = S_XFER;
                    cnt_d    = CW'(1);
                    ptr_d    = ptr_nxt;
                    owner_d  = win;
                    cwr_d    = req_wr[win];
                    cd1_d    = req_d1[32*win +: 32];
                    cd2_d    = req_d2[32*win +: 32];
                    enable_d = 1'b1;
                    wr_d     = 1'b0;
                    sel_d    = req_sel[2*win +: 2];
                    addr_d   = req_addr[32*win +: 32];
                end
            end
            S_XFER: begin
                if (cnt_q == CW'(XFER_CYCLES)) begin
                    state_d  = S_IDLE;
                    enable_d = 1'b0;
                    wr_d     = 1'b0;
                    done_d   = NREQ'(1) << owner_q;
                    if (!cwr_q) rdata_d = d_out;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    wr_d  = cwr_q;
                    // Write data appears together with the first Wr cycle.
                    if (cwr_q && cnt_q == CW'(1)) begin
                        din1_d = cd1_q;
                        din2_d = cd2_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            cwr_q    <= 1'b0;
            cd1_q    <= '0;
            cd2_q    <= '0;
            enable_q <= 1'b0;
            wr_q     <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            din1_q   <= '0;
            din2_q   <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            cwr_q    <= cwr_d;
            cd1_q    <= cd1_d;
            cd2_q    <= cd2_d;
            enable_q <= enable_d;
            wr_q     <= wr_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            din1_q   <= din1_d;
            din2_q   <= din2_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    assign done      = done_q;
    assign rdata     = rdata_q;
    assign enable    = enable_q;
    assign Wr        = wr_q;
    assign slave_sel = sel_q;
    assign addr      = addr_q;
    assign data_in_1 = din1_q;
    assign data_in_2 = din2_q;

endmodule

// File: tb/tb_ahb_txn_arbiter.sv
// Randomized scoreboard bench for ahb_txn_arbiter with a
// list-based round-robin reference model.
module tb_ahb_txn_arbiter;

    localparam int N  = 4;
    localparam int XC = 3;

    logic            Hclk = 1'b0;
    logic            Hresetn;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [2*N-1:0]  req_sel;
    logic [32*N-1:0] req_addr;
    logic [32*N-1:0] req_d1;
    logic [32*N-1:0] req_d2;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     rdata;
    logic            enable;
    logic            Wr;
    logic [1:0]      slave_sel;
    logic [31:0]     addr;
    logic [31:0]     data_in_1;
    logic [31:0]     data_in_2;
    logic [31:0]     d_out;

    ahb_txn_arbiter #(.NREQ(N), .XFER_CYCLES(XC)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .req(req), .req_wr(req_wr),
        .req_sel(req_sel), .req_addr(req_addr), .req_d1(req_d1),
        .req_d2(req_d2), .gnt(gnt), .done(done), .rdata(rdata),
        .enable(enable), .Wr(Wr), .slave_sel(slave_sel), .addr(addr),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .d_out(d_out)
    );

    always #5 Hclk = ~Hclk;

    // Slave model: read data is a fixed scramble of the address.
    function automatic logic [31:0] rd_f(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    assign d_out = rd_f(addr);

    typedef struct {
        int          idx;
        bit          wr;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] ed1;
        logic [31:0] ed2;
        logic [31:0] rd;
    } txn_t;

    int errors = 0;
    int checks = 0;

    txn_t exp_q[$];
    txn_t cur, pend;
    bit   pend_v = 0;
    bit   mon_active = 0;
    int   mon_cyc = 0;
    bit   in_rst = 1;
    logic [N-1:0] last_gnt = '0;

    // Reference model state
    int          m_ptr = 0;
    logic [31:0] m_rd = 0;
    logic [31:0] m_d1 = 0;
    logic [31:0] m_d2 = 0;

    bit          f_wr[N];
    logic [1:0]  f_sel[N];
    logic [31:0] f_addr[N];
    logic [31:0] f_d1[N];
    logic [31:0] f_d2[N];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_fields(input int i, input bit wr,
                              input logic [1:0] sel, input logic [31:0] a,
                              input logic [31:0] d1, input logic [31:0] d2);
        f_wr[i] = wr; f_sel[i] = sel; f_addr[i] = a;
        f_d1[i] = d1; f_d2[i] = d2;
        req_wr[i] = wr;
        req_sel[2*i +: 2] = sel;
        req_addr[32*i +: 32] = a;
        req_d1[32*i +: 32] = d1;
        req_d2[32*i +: 32] = d2;
    endtask

    // Predict the whole grant order for a fixed request set, then
    // hold every request until its grant and wait for completion.
    task automatic run_phase(input logic [N-1:0] mask);
        logic [N-1:0] s;
        txn_t t;
        int budget;
        bit picked;
        s = mask;
        while (s != 0) begin
            picked = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (!picked && s[i]) begin
                    picked = 1;
                    t.idx = i; t.wr = f_wr[i]; t.sel = f_sel[i];
                    t.addr = f_addr[i];
                    if (f_wr[i]) begin
                        m_d1 = f_d1[i]; m_d2 = f_d2[i];
                    end else begin
                        m_rd = rd_f(f_addr[i]);
                    end
                    t.ed1 = m_d1; t.ed2 = m_d2; t.rd = m_rd;
                    exp_q.push_back(t);
                    s[i] = 1'b0;
                    m_ptr = (i + 1) % N;
                end
            end
        end
        req = req | mask;
        budget = 0;
        while ((exp_q.size() != 0 || pend_v || mon_active ||
                (req & mask) != 0) && budget < 200) begin
            @(posedge Hclk); #1;
            req = req & ~last_gnt;
            budget++;
        end
        check("phase_complete", 32'(budget < 200), 32'd1);
        req = req & ~mask;
        exp_q.delete();
        pend_v = 0;
        @(posedge Hclk); #1;
    endtask

    always @(negedge Hclk) begin
        bit just;
        txn_t t;
        if (!in_rst) begin
            just = 0;
            if (enable) begin
                if (!mon_active) begin
                    check("enable_after_grant", 32'(pend_v), 32'd1);
                    mon_active = 1; mon_cyc = 1; cur = pend; pend_v = 0;
                end else begin
                    mon_cyc++;
                end
                check("enable_len_max", 32'(mon_cyc <= XC), 32'd1);
                check("slave_sel", 32'(slave_sel), 32'(cur.sel));
                check("addr", addr, cur.addr);
                check("Wr", 32'(Wr), 32'(cur.wr && mon_cyc >= 2));
                if (mon_cyc >= 2) begin
                    check("data_in_1", data_in_1, cur.ed1);
                    check("data_in_2", data_in_2, cur.ed2);
                end
            end else if (mon_active) begin
                check("enable_len", mon_cyc, XC);
                check("done", 32'(done), 32'd1 << cur.idx);
                check("rdata", rdata, cur.rd);
                mon_active = 0;
                just = 1;
            end else begin
                check("no_done", 32'(done), 32'd0);
            end
            last_gnt = gnt;
            if (gnt != 0) begin
                check("gnt_while_busy", 32'(enable), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    check("gnt", 32'(gnt), 32'd1 << t.idx);
                    pend = t; pend_v = 1;
                end
            end else if (just && exp_q.size() != 0) begin
                check("b2b_gnt", 32'(gnt), 32'd1 << exp_q[0].idx);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, 32'(enable), 32'd0);
        check({tag, "_Wr"}, 32'(Wr), 32'd0);
        check({tag, "_sel"}, 32'(slave_sel), 32'd0);
        check({tag, "_addr"}, addr, 32'd0);
        check({tag, "_d1"}, data_in_1, 32'd0);
        check({tag, "_d2"}, data_in_2, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        Hresetn = 1'b0;
        req = '1;
        req_wr = '0; req_sel = '0; req_addr = '0;
        req_d1 = '0; req_d2 = '0;
        repeat (3) @(posedge Hclk);
        #1;
        check_all_zero("reset");
        req = '0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        in_rst = 0;
        @(posedge Hclk); #1;

        // Single write then read-back on requester 0
        set_fields(0, 1, 2'b00, 32'd1, 32'd5, 32'd10);
        run_phase(4'b0001);
        set_fields(0, 0, 2'b00, 32'd1, 32'd0, 32'd0);
        run_phase(4'b0001);

        // ptr ends at 2, then 3 and 1 compete: 3 wins, wrap, then 1
        set_fields(1, 1, 2'b01, 32'h100, 32'h11, 32'h22);
        run_phase(4'b0010);
        set_fields(3, 0, 2'b11, 32'h300, 32'h0, 32'h0);
        set_fields(1, 1, 2'b10, 32'h104, 32'h33, 32'h44);
        run_phase(4'b1010);

        // req[2] pulses only while a transfer is in flight
        set_fields(2, 1, 2'b10, 32'h200, 32'h55, 32'h66);
        set_fields(0, 0, 2'b01, 32'h40, 32'h0, 32'h0);
        fork
            run_phase(4'b0001);
            begin
                int w;
                w = 0;
                @(negedge Hclk);
                while (!enable && w < 20) begin
                    @(negedge Hclk); w++;
                end
                req[2] = 1'b1;
                @(negedge Hclk);
                req[2] = 1'b0;
            end
        join

        // Asynchronous reset during cycle 2 of a write
        set_fields(0, 1, 2'b11, 32'h77, 32'hAA, 32'hBB);
        fork
            run_phase(4'b0001);
            begin
                int w;
                w = 0;
                @(negedge Hclk);
                while (!enable && w < 20) begin
                    @(negedge Hclk); w++;
                end
                @(posedge Hclk); #3;
                in_rst = 1;
                Hresetn = 1'b0;
                #1;
                check_all_zero("midrst");
                exp_q.delete();
                pend_v = 0; mon_active = 0; req = '0;
                m_ptr = 0; m_rd = 0; m_d1 = 0; m_d2 = 0;
                repeat (2) @(posedge Hclk);
                #3;
                Hresetn = 1'b1;
                in_rst = 0;
                repeat (3) begin
                    @(negedge Hclk);
                    check("idle_after_rst", 32'(enable), 32'd0);
                end
            end
        join

        // All four from a fresh ptr of 0
        for (int i = 0; i < N; i++)
            set_fields(i, 1, 2'(i), 32'(i + 1), 32'(i * 16 + 1), 32'(i * 16 + 2));
        run_phase(4'b1111);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++)
                set_fields(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           $urandom, $urandom, $urandom);
            run_phase(4'($urandom_range(1, 15)));
        end

        repeat (4) @(posedge Hclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
